// File: rtl/cellnet_arbiter_pkg.sv
// Shared cellnet link constants: bus widths, link levels and arbiter state codes.
// Imported by the arbiter and its round-robin picker.
package cellnet_arbiter_pkg;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

   localparam int ADDRESS_SIZE = 8;
   localparam int DATA_SIZE    = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;
   localparam logic [1:0] ST_DROP = 2'd3;

endpackage

// File: rtl/cellnet_arbiter_rr_pick.sv
// Combinational round-robin search: first set request strictly after ptr,
// wrapping at N_SRC-1, so the previous winner is considered last.
module rr_pick #(
   parameter int N_SRC = 4,
   parameter int IDX_W = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] win,
   output logic             found
);

   // NOTE: outputs get defaults before the search so no path leaves them unassigned (no latch).
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int i = 1; i <= N_SRC; i++) begin
         int idx;
         idx = (int'(ptr) + i) % N_SRC;
         if (!found && req[idx]) begin
            win   = IDX_W'(idx);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cellnet_arbiter.sv
// Round-robin arbiter sharing one cellnet sink among N_SRC sources over the
// four-phase req/ack link, with an abort if the sink never acknowledges.
module cellnet_arbiter
   import cellnet_arbiter_pkg::*;
#(
   parameter int N_SRC   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [N_SRC-1:0]               i_req,
   input  logic [N_SRC*ADDRESS_SIZE-1:0]  i_addr,
   input  logic [N_SRC*DATA_SIZE-1:0]     i_dat,
   output logic [N_SRC-1:0]               o_ack,
   output logic                           o_snk_req,
   output logic [ADDRESS_SIZE-1:0]        o_snk_addr,
   output logic [DATA_SIZE-1:0]           o_snk_dat,
   input  logic                           i_snk_ack,
   output logic                           o_busy,
   output logic [$clog2(N_SRC)-1:0]       o_grant,
   output logic                           o_timeout
);

   localparam int IDX_W = $clog2(N_SRC);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_SRC - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]       state;
   logic [IDX_W-1:0] ptr;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] win;
   logic             found;

   rr_pick #(
      .N_SRC (N_SRC),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (i_req),
      .ptr   (ptr),
      .win   (win),
      .found (found)
   );

   assign o_busy = (state != ST_IDLE);

   // NOTE: all state here is updated with non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         ptr        <= PTR_RST;
         cnt        <= '0;
         o_ack      <= '0;
         o_snk_req  <= OFF;
         o_snk_addr <= '0;
         o_snk_dat  <= '0;
         o_grant    <= '0;
         o_timeout  <= OFF;
      end else begin
         o_timeout <= OFF;
         case (state)
            ST_IDLE: begin
               if (found) begin
                  o_grant    <= win;
                  o_snk_addr <= i_addr[win*ADDRESS_SIZE +: ADDRESS_SIZE];
                  o_snk_dat  <= i_dat[win*DATA_SIZE +: DATA_SIZE];
                  o_snk_req  <= ON;
                  cnt        <= '0;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               // A late ack on the final count still completes the transfer.
               if (i_snk_ack) begin
                  o_ack[o_grant] <= ON;
                  state          <= ST_ACK;
               end else if (cnt == CNT_LAST) begin
                  o_timeout <= ON;
                  o_snk_req <= OFF;
                  state     <= ST_DROP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_ACK: begin
               if (!i_req[o_grant]) begin
                  o_snk_req <= OFF;
                  state     <= ST_DROP;
               end
            end
            ST_DROP: begin
               // Aborted transfers advance ptr too, so a stalled source cannot hog the sink.
               if (!i_snk_ack) begin
                  o_ack <= '0;
                  ptr   <= o_grant;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cellnet_arbiter.sv
// Directed bench for cellnet_arbiter: reactive source/sink models driven on the
// falling edge, transfer-level checks against hand-computed expectations.
module tb_cellnet_arbiter;
   import cellnet_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int TO = 8;
   localparam int AW = ADDRESS_SIZE;
   localparam int DW = DATA_SIZE;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic [N-1:0]      i_req;
   logic [N*AW-1:0]   i_addr;
   logic [N*DW-1:0]   i_dat;
   logic [N-1:0]      o_ack;
   logic              o_snk_req;
   logic [AW-1:0]     o_snk_addr;
   logic [DW-1:0]     o_snk_dat;
   logic              i_snk_ack;
   logic              o_busy;
   logic [1:0]        o_grant;
   logic              o_timeout;

   always #5 i_clk = ~i_clk;

   cellnet_arbiter #(
      .N_SRC   (N),
      .TIMEOUT (TO)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_dat      (i_dat),
      .o_ack      (o_ack),
      .o_snk_req  (o_snk_req),
      .o_snk_addr (o_snk_addr),
      .o_snk_dat  (o_snk_dat),
      .i_snk_ack  (i_snk_ack),
      .o_busy     (o_busy),
      .o_grant    (o_grant),
      .o_timeout  (o_timeout)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [N-1:0]  want;
   bit            rereq;
   int            sink_delay;
   int            rc;
   int            viol;
   logic [AW-1:0] addr_tab [N];
   logic [DW-1:0] dat_tab  [N];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One falling edge: watch ack legality, then let sources and sink react.
   task automatic step();
      @(negedge i_clk);
      if (o_ack != '0 && !o_busy) viol++;
      if ($countones(o_ack) > 1) viol++;
      for (int k = 0; k < N; k++) begin
         if (o_ack[k]) begin
            i_req[k] = 1'b0;
            if (!rereq) want[k] = 1'b0;
         end else begin
            i_req[k] = want[k];
         end
         i_addr[k*AW +: AW] = addr_tab[k];
         i_dat[k*DW +: DW]  = dat_tab[k];
      end
      if (o_snk_req) begin
         i_snk_ack = (rc >= sink_delay);
         rc++;
      end else begin
         i_snk_ack = 1'b0;
         rc = 0;
      end
   endtask

   task automatic run_xfer(input string tag, input int exp_g, input int exp_busy,
                           input int exp_to, input logic [N-1:0] exp_ack, input bit poke);
      int            wait_cyc = 0;
      int            busy = 0;
      int            to_cnt = 0;
      int            to_at = -1;
      int            unstable = 0;
      logic          req_at_to = 1'b1;
      logic [N-1:0]  acks = '0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      int            g;
      while (!o_busy && wait_cyc < 50) begin
         step();
         wait_cyc++;
      end
      if (!o_busy) begin
         check({tag, "_start"}, 32'(o_busy), 32'd1);
         return;
      end
      g  = int'(o_grant);
      a0 = o_snk_addr;
      d0 = o_snk_dat;
      check({tag, "_grant"}, 32'(o_grant), 32'(exp_g));
      check({tag, "_addr"}, 32'(a0), 32'(addr_tab[exp_g]));
      check({tag, "_dat"}, 32'(d0), 32'(dat_tab[exp_g]));
      while (o_busy && busy < 100) begin
         busy++;
         acks |= o_ack;
         if (o_timeout) begin
            to_cnt++;
            if (to_at < 0) begin
               to_at     = busy - 1;
               req_at_to = o_snk_req;
            end
         end
         if (o_snk_addr !== a0 || o_snk_dat !== d0) unstable++;
         if (poke && busy == 2) begin
            dat_tab[g]  = dat_tab[g] ^ 8'hFF;
            addr_tab[g] = addr_tab[g] ^ 8'h5A;
         end
         step();
      end
      check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
      check({tag, "_tmo"}, 32'(to_cnt), 32'(exp_to));
      check({tag, "_ack"}, 32'(acks), 32'(exp_ack));
      check({tag, "_stable"}, 32'(unstable), 32'd0);
      if (exp_to != 0) begin
         check({tag, "_tmo_at"}, 32'(to_at), 32'(TO));
         check({tag, "_req_at_tmo"}, 32'(req_at_to), 32'd0);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_snk_req"}, 32'(o_snk_req), 32'd0);
      check({tag, "_ack"}, 32'(o_ack), 32'd0);
      check({tag, "_busy"}, 32'(o_busy), 32'd0);
      check({tag, "_tmo"}, 32'(o_timeout), 32'd0);
      check({tag, "_grant"}, 32'(o_grant), 32'd0);
      check({tag, "_addr"}, 32'(o_snk_addr), 32'd0);
      check({tag, "_dat"}, 32'(o_snk_dat), 32'd0);
   endtask

   initial begin
      i_rst      = 1'b1;
      i_req      = '0;
      i_addr     = '0;
      i_dat      = '0;
      i_snk_ack  = 1'b0;
      want       = '0;
      rereq      = 1'b0;
      sink_delay = 1;
      rc         = 0;
      viol       = 0;
      for (int k = 0; k < N; k++) begin
         addr_tab[k] = 8'(8'h10 + k);
         dat_tab[k]  = 8'(8'hC0 + k);
      end
      addr_tab[1] = 8'd3;
      dat_tab[1]  = 8'hA5;

      step();
      step();
      check_zero("rst");
      i_rst = 1'b0;
      step();

      // Lone requester 1, sink acks one cycle after req.
      want = 4'b0010;
      run_xfer("single", 1, 4, 0, 4'b0010, 1'b0);

      // Reset while in ACK.
      want = 4'b0100;
      for (int i = 0; i < 20 && o_ack == '0; i++) step();
      check("reach_ack", 32'(o_ack), 32'h4);
      check("reach_ack_addr", 32'(o_snk_addr), 32'h12);
      i_rst = 1'b1;
      step();
      check_zero("rst_ack");
      i_rst = 1'b0;

      // Contention from reset pointer: 0,1,2,3,0 then 1 with re-request off.
      want  = 4'b1111;
      rereq = 1'b1;
      run_xfer("cont0", 0, 4, 0, 4'b0001, 1'b0);
      run_xfer("cont1", 1, 4, 0, 4'b0010, 1'b0);
      run_xfer("cont2", 2, 4, 0, 4'b0100, 1'b0);
      run_xfer("cont3", 3, 4, 0, 4'b1000, 1'b0);
      run_xfer("cont4", 0, 4, 0, 4'b0001, 1'b0);
      rereq = 1'b0;
      run_xfer("cont5", 1, 4, 0, 4'b0010, 1'b0);
      run_xfer("drain2", 2, 4, 0, 4'b0100, 1'b0);
      run_xfer("drain3", 3, 4, 0, 4'b1000, 1'b0);
      run_xfer("drain0", 0, 4, 0, 4'b0001, 1'b0);
      check("drained", 32'(want), 32'd0);

      // Wrap: serve 3, then 1001 gives 0 before 3.
      want = 4'b1000;
      run_xfer("wrap_a", 3, 4, 0, 4'b1000, 1'b0);
      want = 4'b1001;
      run_xfer("wrap_b", 0, 4, 0, 4'b0001, 1'b0);
      run_xfer("wrap_c", 3, 4, 0, 4'b1000, 1'b0);

      // Silent sink: requester 0 times out, then 1 goes next, then 0 retries.
      sink_delay = 100;
      want = 4'b0011;
      run_xfer("tmo", 0, 9, 1, 4'b0000, 1'b0);
      sink_delay = 1;
      run_xfer("after_tmo", 1, 4, 0, 4'b0010, 1'b0);
      run_xfer("retry", 0, 4, 0, 4'b0001, 1'b0);

      // Ack arriving on the last count wins over the timeout.
      sink_delay = 7;
      want = 4'b0100;
      run_xfer("late_ack", 2, 10, 0, 4'b0100, 1'b0);

      // Winner's inputs change during REQ; latched outputs must hold.
      sink_delay = 3;
      want = 4'b1000;
      run_xfer("stable", 3, 6, 0, 4'b1000, 1'b1);

      check("ack_legal", 32'(viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
